// File: rtl/gpu_cmd_pkg.sv
// Shared constants for the command-list DMA: register map, control/status bits,
// list header layout, FSM encodings and gpu_core register indices.
package gpu_cmd_pkg;

  localparam logic [1:0] REG_BASE   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_ACK = 2;

  localparam int STATUS_BUSY = 31;
  localparam int STATUS_DONE = 30;

  localparam int HDR_END = 31;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] GPU_REG_COLOR = 4'd1;
  localparam logic [3:0] GPU_REG_ZC    = 4'd15;

  function automatic logic isEndHeader(input logic [31:0] word);
    return word[HDR_END];
  endfunction

  function automatic logic [3:0] headerReg(input logic [31:0] word);
    return word[3:0];
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous show-ahead FIFO: data_o always presents the oldest entry while not empty.
module gpu_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   usedw_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   USED_ONE = 1;
  localparam logic [AW:0]   USED_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      used_q;
  logic             doPush, doPop;

  assign empty_o = (used_q == '0);
  assign full_o  = (used_q == USED_MAX);
  assign usedw_o = used_q;
  assign data_o  = mem[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      used_q  <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      if (doPush && !doPop)      used_q <= used_q + USED_ONE;
      else if (doPop && !doPush) used_q <= used_q - USED_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/gpu_cmd_dma.sv
// Command-list fetcher: streams {header,data} pairs from SDRAM into gpu_core writes.
// Define GPU_CMD_DMA_IRQ_EN to enable the list-complete interrupt.
module gpu_cmd_dma
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  ctl_address_i,
  input  logic        ctl_read_en_i,
  input  logic        ctl_write_en_i,
  input  logic [31:0] ctl_write_data_i,
  output logic [31:0] ctl_read_data_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  input  logic        mem_wait_request_i,
  input  logic [31:0] mem_read_data_i,
  input  logic        mem_read_valid_i,
  output logic [3:0]  gpu_address_o,
  output logic        gpu_write_o,
  output logic [31:0] gpu_write_data_o,
  input  logic        gpu_wait_request_i,
  output logic        irq_o
);

  localparam int UW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [UW:0]      DEPTH_L = (UW+1)'(FIFO_DEPTH);
  localparam logic [UW-1:0]    OUT_ONE = 1;
  localparam logic [CNT_W:0]   RL_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      base_q, base_d, addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d, cmdsLeft_q, cmdsLeft_d;
  logic [CNT_W:0]   readsLeft_q, readsLeft_d;
  logic [UW-1:0]    outstanding_q, outstanding_d;
  logic             done_q, done_d, discard_q, discard_d;
  logic             hdrValid_q, hdrValid_d, hdrEnd_q, hdrEnd_d;
  logic [3:0]       hdrReg_q, hdrReg_d, gpuAddr_q, gpuAddr_d;
  logic             gpuWrite_q, gpuWrite_d;
  logic [31:0]      gpuData_q, gpuData_d;

  logic             fifoPush, fifoPop, fifoEmpty, fifoFull;
  logic [31:0]      fifoData;
  logic [UW-1:0]    fifoUsed;
  logic [UW:0]      inFlight;
  logic             isIdle, wrBase, wrCount, wrCtrl, startReq, abortReq;
  logic             memAccept, retire, popHdr, popData;
  logic [31:0]      status;

  gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) uFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  (mem_read_data_i),
    .data_o  (fifoData),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull),
    .usedw_o (fifoUsed)
  );

  assign isIdle   = (state_q == ST_IDLE);
  assign wrBase   = ctl_write_en_i && (ctl_address_i == REG_BASE);
  assign wrCount  = ctl_write_en_i && (ctl_address_i == REG_COUNT);
  assign wrCtrl   = ctl_write_en_i && (ctl_address_i == REG_CTRL);
  assign startReq = wrCtrl && ctl_write_data_i[CTRL_START];
  assign abortReq = wrCtrl && ctl_write_data_i[CTRL_ABORT] && !isIdle;

  // Reads only go out while the FIFO can absorb every return already in flight.
  assign inFlight   = {1'b0, outstanding_q} + {1'b0, fifoUsed};
  assign mem_read_o = (state_q == ST_FETCH) && (readsLeft_q != '0) && (inFlight < DEPTH_L)
                      && !abortReq && !discard_q;
  assign memAccept  = mem_read_o && !mem_wait_request_i;
  assign retire     = mem_read_valid_i && (outstanding_q != '0);

  assign fifoPush = retire && !discard_q && !fifoFull;
  assign popHdr   = !fifoEmpty && !discard_q && !abortReq && !hdrValid_q;
  assign popData  = !fifoEmpty && !discard_q && !abortReq && hdrValid_q
                    && (!gpuWrite_q || !gpu_wait_request_i);
  assign fifoPop  = popHdr || popData || (!fifoEmpty && discard_q);

  assign mem_address_o    = addr_q;
  assign gpu_write_o      = gpuWrite_q;
  assign gpu_address_o    = gpuAddr_q;
  assign gpu_write_data_o = gpuData_q;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    done_d        = done_q;
    addr_d        = addr_q;
    readsLeft_d   = readsLeft_q;
    cmdsLeft_d    = cmdsLeft_q;
    outstanding_d = outstanding_q;
    hdrValid_d    = hdrValid_q;
    hdrReg_d      = hdrReg_q;
    hdrEnd_d      = hdrEnd_q;
    discard_d     = discard_q;
    gpuWrite_d    = gpuWrite_q;
    gpuAddr_d     = gpuAddr_q;
    gpuData_d     = gpuData_q;

    if (isIdle && wrBase)  base_d  = {ctl_write_data_i[31:2], 2'b00};
    if (isIdle && wrCount) count_d = ctl_write_data_i[CNT_W-1:0];

    if (memAccept) begin
      addr_d      = addr_q + 32'd4;
      readsLeft_d = readsLeft_q - RL_ONE;
    end
    if (memAccept && !retire)      outstanding_d = outstanding_q + OUT_ONE;
    else if (retire && !memAccept) outstanding_d = outstanding_q - OUT_ONE;

    if (popHdr) begin
      hdrValid_d = 1'b1;
      hdrReg_d   = headerReg(fifoData);
      hdrEnd_d   = isEndHeader(fifoData);
    end
    if (gpuWrite_q && !gpu_wait_request_i) gpuWrite_d = 1'b0;
    // The END command's data word is still written; everything behind it is flushed.
    if (popData) begin
      gpuWrite_d = 1'b1;
      gpuAddr_d  = hdrReg_q;
      gpuData_d  = fifoData;
      hdrValid_d = 1'b0;
      cmdsLeft_d = cmdsLeft_q - CNT_ONE;
      if (hdrEnd_q) discard_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (startReq) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_FETCH;
            done_d      = 1'b0;
            addr_d      = base_q;
            readsLeft_d = {count_q, 1'b0};
            cmdsLeft_d  = count_q;
            discard_d   = 1'b0;
            hdrValid_d  = 1'b0;
          end
        end
      end
      ST_FETCH: begin
        if ((readsLeft_q == '0) || (popHdr && isEndHeader(fifoData))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && fifoEmpty && !gpuWrite_q) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          hdrValid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abortReq) begin
      state_d    = ST_DRAIN;
      discard_d  = 1'b1;
      hdrValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      addr_q        <= '0;
      readsLeft_q   <= '0;
      cmdsLeft_q    <= '0;
      outstanding_q <= '0;
      hdrValid_q    <= 1'b0;
      hdrReg_q      <= '0;
      hdrEnd_q      <= 1'b0;
      discard_q     <= 1'b0;
      gpuWrite_q    <= 1'b0;
      gpuAddr_q     <= '0;
      gpuData_q     <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      done_q        <= done_d;
      addr_q        <= addr_d;
      readsLeft_q   <= readsLeft_d;
      cmdsLeft_q    <= cmdsLeft_d;
      outstanding_q <= outstanding_d;
      hdrValid_q    <= hdrValid_d;
      hdrReg_q      <= hdrReg_d;
      hdrEnd_q      <= hdrEnd_d;
      discard_q     <= discard_d;
      gpuWrite_q    <= gpuWrite_d;
      gpuAddr_q     <= gpuAddr_d;
      gpuData_q     <= gpuData_d;
    end
  end

  always_comb begin
    status              = '0;
    status[STATUS_BUSY] = !isIdle;
    status[STATUS_DONE] = done_q;
    status[CNT_W-1:0]   = cmdsLeft_q;
    ctl_read_data_o     = '0;
    if (ctl_read_en_i) begin
      case (ctl_address_i)
        REG_BASE:   ctl_read_data_o = base_q;
        REG_COUNT:  ctl_read_data_o = 32'(count_q);
        REG_STATUS: ctl_read_data_o = status;
        default:    ctl_read_data_o = '0;
      endcase
    end
  end

`ifdef GPU_CMD_DMA_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (wrCtrl && ctl_write_data_i[CTRL_IRQ_ACK]) irq_d = 1'b0;
    if (done_d && !done_q) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_cmd_dma.sv
// Directed bench for gpu_cmd_dma with an SDRAM read model and a gpu_core slave model.
module tb_gpu_cmd_dma;
  import gpu_cmd_pkg::*;

`ifdef GPU_CMD_DMA_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctlAddress;
  logic        ctlReadEn, ctlWriteEn;
  logic [31:0] ctlWriteData, ctlReadData;
  logic [31:0] memAddress, memData;
  logic        memRead, memWait, memValid;
  logic [3:0]  gpuAddress;
  logic        gpuWrite, gpuWait, irq;
  logic [31:0] gpuWriteData;

  gpu_cmd_dma #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ctl_address_i      (ctlAddress),
    .ctl_read_en_i      (ctlReadEn),
    .ctl_write_en_i     (ctlWriteEn),
    .ctl_write_data_i   (ctlWriteData),
    .ctl_read_data_o    (ctlReadData),
    .mem_address_o      (memAddress),
    .mem_read_o         (memRead),
    .mem_wait_request_i (memWait),
    .mem_read_data_i    (memData),
    .mem_read_valid_i   (memValid),
    .gpu_address_o      (gpuAddress),
    .gpu_write_o        (gpuWrite),
    .gpu_write_data_o   (gpuWriteData),
    .gpu_wait_request_i (gpuWait),
    .irq_o              (irq)
  );

  always #5 clk = ~clk;

  // SDRAM and gpu_core models share one cycle counter so the stall patterns are repeatable
  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] sdram [0:1023];
  ret_t        pend [$];
  int          cyc = 0, lat = 2;
  bit          memToggle = 0, slowGpu = 0;
  int          rdCount = 0, nWrites = 0, stallSeen = 0, stallTarget = 0;
  int          holdErrs = 0, addrErrs = 0, maxIF = 0;
  int          rdBase = 0, wrBase = 0;
  logic [31:0] addrBase = '0;
  logic [3:0]  gotA [0:511];
  logic [31:0] gotD [0:511];
  logic        prevHeld = 1'b0;
  logic [3:0]  prevA = '0;
  logic [31:0] prevD = '0;
  int          checks = 0, failures = 0;

  assign memWait = memToggle && ((cyc % 3) == 1);
  assign gpuWait = slowGpu ? ((cyc % 5) != 0) : (stallSeen < stallTarget);

  // SDRAM: in-order returns, at least lat cycles after acceptance
  always @(posedge clk) begin : sdramModel
    int inf;
    cyc <= cyc + 1;
    if (memRead && !memWait) begin
      pend.push_back('{due: 32'(cyc + lat), data: sdram[memAddress[11:2]]});
      rdCount <= rdCount + 1;
      if (memAddress != addrBase + 32'(4 * (rdCount - rdBase))) addrErrs <= addrErrs + 1;
    end
    if (pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
      memValid <= 1'b1;
      memData  <= pend[0].data;
      void'(pend.pop_front());
    end else begin
      memValid <= 1'b0;
    end
    inf = rdCount - 2 * (nWrites + int'(gpuWrite));
    if (inf > maxIF) maxIF <= inf;
  end

  always @(posedge clk) begin : gpuModel
    if (gpuWrite && !gpuWait) begin
      gotA[nWrites] <= gpuAddress;
      gotD[nWrites] <= gpuWriteData;
      nWrites       <= nWrites + 1;
    end
    if (gpuWrite && gpuWait) stallSeen <= stallSeen + 1;
    if (prevHeld && (!gpuWrite || gpuAddress != prevA || gpuWriteData != prevD))
      holdErrs <= holdErrs + 1;
    prevHeld <= gpuWrite && gpuWait;
    prevA    <= gpuAddress;
    prevD    <= gpuWriteData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    ctlAddress   = a;
    ctlWriteData = d;
    ctlWriteEn   = 1'b1;
    @(negedge clk);
    ctlWriteEn   = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    ctlAddress = a;
    ctlReadEn  = 1'b1;
    #1 d = ctlReadData;
    ctlReadEn  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] count);
    @(negedge clk);
    addrBase = base;
    rdBase   = rdCount;
    wrBase   = nWrites;
    writeReg(REG_BASE, base);
    writeReg(REG_COUNT, count);
    writeReg(REG_CTRL, 32'h1);
  endtask

  task automatic waitIdle(input int maxCyc);
    logic [31:0] s;
    int n = 0;
    readReg(REG_STATUS, s);
    while (s[31] && n < maxCyc) begin
      @(negedge clk);
      readReg(REG_STATUS, s);
      n++;
    end
    checkOutput("idleTimeout", {31'b0, s[31]}, 32'h0);
  endtask

  initial begin : stimulus
    logic [31:0] rd;
    int ordErrs, expW, rdSnap, n;

    rst = 1'b1; ctlAddress = '0; ctlReadEn = 1'b0; ctlWriteEn = 1'b0; ctlWriteData = '0;
    for (int i = 0; i < 1024; i++) sdram[i] = 32'hFFFF_0000 | 32'(i);
    sdram[64] = 32'h1; sdram[65] = 32'hF800; sdram[66] = 32'h2; sdram[67] = 32'h12345;
    for (int i = 0; i < 8; i++) begin
      sdram[128 + 2*i]     = (i == 2) ? 32'h8000_0008 : 32'(i + 3);
      sdram[128 + 2*i + 1] = (i == 2) ? 32'hDEAD : 32'(32'h100 + i);
    end
    for (int i = 0; i < 100; i++) begin
      sdram[256 + 2*i]     = 32'((i % 15) + 1);
      sdram[256 + 2*i + 1] = 32'(32'h1000 + i);
    end
    for (int i = 0; i < 50; i++) begin
      sdram[512 + 2*i]     = 32'((i % 15) + 1);
      sdram[512 + 2*i + 1] = 32'(32'h5000 + i);
    end

    repeat (3) @(negedge clk);
    checkOutput("rstMemRead", {31'b0, memRead}, 32'h0);
    checkOutput("rstMemAddr", memAddress, 32'h0);
    checkOutput("rstGpuWrite", {31'b0, gpuWrite}, 32'h0);
    checkOutput("rstIrq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    readReg(REG_STATUS, rd);
    checkOutput("rstStatus", rd, 32'h0);

    // Start with COUNT=0 completes immediately without touching memory
    @(negedge clk);
    writeReg(REG_COUNT, 32'h0);
    writeReg(REG_CTRL, 32'h1);
    readReg(REG_STATUS, rd);
    checkOutput("zeroStatus", rd, 32'h4000_0000);
    checkOutput("zeroIrq", {31'b0, irq}, {31'b0, IRQ_EXP});
    repeat (3) @(negedge clk);
    checkOutput("zeroReads", 32'(rdCount), 32'h0);
    writeReg(REG_CTRL, 32'h4);
    checkOutput("zeroIrqAck", {31'b0, irq}, 32'h0);

    writeReg(REG_BASE, 32'h103);
    readReg(REG_BASE, rd);
    checkOutput("baseAlign", rd, 32'h100);

    // Two-command list, no back-pressure
    applyStimulus(32'h100, 32'd2);
    waitIdle(500);
    checkOutput("t1Writes", 32'(nWrites - wrBase), 32'd2);
    checkOutput("t1A0", {28'b0, gotA[wrBase]}, 32'h1);
    checkOutput("t1D0", gotD[wrBase], 32'hF800);
    checkOutput("t1A1", {28'b0, gotA[wrBase+1]}, 32'h2);
    checkOutput("t1D1", gotD[wrBase+1], 32'h12345);
    readReg(REG_STATUS, rd);
    checkOutput("t1Status", rd, 32'h4000_0000);
    checkOutput("t1Irq", {31'b0, irq}, {31'b0, IRQ_EXP});
    @(negedge clk);
    writeReg(REG_CTRL, 32'h4);

    // Same list, first gpu write stalled for 5 cycles
    stallTarget = stallSeen + 5;
    applyStimulus(32'h100, 32'd2);
    waitIdle(500);
    checkOutput("t2Writes", 32'(nWrites - wrBase), 32'd2);
    checkOutput("t2D0", gotD[wrBase], 32'hF800);
    checkOutput("t2D1", gotD[wrBase+1], 32'h12345);
    checkOutput("t2Stalls", 32'(stallSeen), 32'(stallTarget));
    checkOutput("t2Hold", 32'(holdErrs), 32'h0);

    // Long list with SDRAM stalls, latency 7 and a slow gpu_core
    lat = 7; memToggle = 1; slowGpu = 1;
    applyStimulus(32'h400, 32'd100);
    repeat (5) @(negedge clk);
    writeReg(REG_COUNT, 32'd5);
    readReg(REG_COUNT, rd);
    checkOutput("t4CountBusy", rd, 32'd100);
    waitIdle(8000);
    checkOutput("t4Writes", 32'(nWrites - wrBase), 32'd100);
    ordErrs = 0;
    for (int i = 0; i < 100; i++)
      if (gotA[wrBase+i] != 4'((i % 15) + 1) || gotD[wrBase+i] != 32'(32'h1000 + i)) ordErrs++;
    checkOutput("t4Order", 32'(ordErrs), 32'h0);
    checkOutput("t4Reads", 32'(rdCount - rdBase), 32'd200);
    checkOutput("t4Addr", 32'(addrErrs), 32'h0);
    checkOutput("t4InFlight", {31'b0, maxIF <= 17}, 32'h1);
    lat = 2; memToggle = 0; slowGpu = 0;

    // END header on the third command
    applyStimulus(32'h200, 32'd8);
    waitIdle(1000);
    checkOutput("t3Writes", 32'(nWrites - wrBase), 32'd3);
    checkOutput("t3A0", {28'b0, gotA[wrBase]}, 32'h3);
    checkOutput("t3A2", {28'b0, gotA[wrBase+2]}, 32'h8);
    checkOutput("t3D2", gotD[wrBase+2], 32'hDEAD);
    readReg(REG_STATUS, rd);
    checkOutput("t3Status", {30'b0, rd[31:30]}, 32'h1);
    checkOutput("t3Pending", 32'(pend.size()), 32'h0);
    checkOutput("t3Addr", 32'(addrErrs), 32'h0);

    // Abort after 10 writes of a 50-command list
    @(negedge clk);
    writeReg(REG_CTRL, 32'h4);
    checkOutput("t5IrqClr", {31'b0, irq}, 32'h0);
    slowGpu = 1;
    applyStimulus(32'h800, 32'd50);
    n = 0;
    while ((nWrites - wrBase) < 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5Progress", {31'b0, (nWrites - wrBase) >= 10}, 32'h1);
    expW   = nWrites - wrBase + int'(gpuWrite);
    rdSnap = rdCount;
    writeReg(REG_CTRL, 32'h2);
    waitIdle(3000);
    repeat (10) @(negedge clk);
    checkOutput("t5Writes", 32'(nWrites - wrBase), 32'(expW));
    ordErrs = 0;
    for (int i = 0; i < expW; i++)
      if (gotA[wrBase+i] != 4'((i % 15) + 1) || gotD[wrBase+i] != 32'(32'h5000 + i)) ordErrs++;
    checkOutput("t5Order", 32'(ordErrs), 32'h0);
    checkOutput("t5NoReads", 32'(rdCount), 32'(rdSnap));
    readReg(REG_STATUS, rd);
    checkOutput("t5Status", {30'b0, rd[31:30]}, 32'h1);
    checkOutput("t5Irq", {31'b0, irq}, {31'b0, IRQ_EXP});

    // Reset in the middle of a list
    applyStimulus(32'h800, 32'd50);
    n = 0;
    while (!gpuWrite && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t7Started", {31'b0, gpuWrite}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t7GpuWrite", {31'b0, gpuWrite}, 32'h0);
    checkOutput("t7GpuAddr", {28'b0, gpuAddress}, 32'h0);
    checkOutput("t7GpuData", gpuWriteData, 32'h0);
    checkOutput("t7MemRead", {31'b0, memRead}, 32'h0);
    checkOutput("t7MemAddr", memAddress, 32'h0);
    checkOutput("t7Irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rdSnap = rdCount;
    expW   = nWrites;
    repeat (20) @(negedge clk);
    readReg(REG_STATUS, rd);
    checkOutput("t7Status", rd, 32'h0);
    checkOutput("t7NoWrites", 32'(nWrites), 32'(expW));
    checkOutput("t7NoReads", 32'(rdCount), 32'(rdSnap));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
